// File: rtl/fifo_ctrl_if.sv
// Producer/consumer and RAM-side signals of fifo_ctrl; overflow/underflow exist only with FIFO_ERR_FLAGS_EN.
// Combinational strobes, 1-cycle rd_valid; wr_en/rd_en are requests that the controller may refuse when full/empty.
interface fifo_ctrl_if #(
  parameter int ADDR_W     = 4,
  parameter int RAM_ADDR_W = 5
);
  logic                  wr_en;
  logic                  rd_en;
  logic                  ram_we;
  logic [RAM_ADDR_W-1:0] ram_waddr;
  logic                  ram_re;
  logic [RAM_ADDR_W-1:0] ram_raddr;
  logic                  rd_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic [ADDR_W:0]       count;
`ifdef FIFO_ERR_FLAGS_EN
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr_en, rd_en,
    input  ram_we, ram_waddr, ram_re, ram_raddr, rd_valid,
    input  full, empty, almost_full, count, overflow, underflow
  );

  modport slave (
    input  wr_en, rd_en,
    output ram_we, ram_waddr, ram_re, ram_raddr, rd_valid,
    output full, empty, almost_full, count, overflow, underflow
  );
`else
  modport master (
    output wr_en, rd_en,
    input  ram_we, ram_waddr, ram_re, ram_raddr, rd_valid,
    input  full, empty, almost_full, count
  );

  modport slave (
    input  wr_en, rd_en,
    output ram_we, ram_waddr, ram_re, ram_raddr, rd_valid,
    output full, empty, almost_full, count
  );
`endif
endinterface

// File: rtl/fifo_ctrl.sv
// Wrap-bit pointer FIFO controller for a registered-read dual-port RAM; FIFO_ERR_FLAGS_EN adds sticky overflow/underflow.
// Strobes in the request cycle, rd_valid one cycle after ram_re; pushes refused when full, pops refused when empty.
module fifo_ctrl #(
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 4,
  parameter int RAM_ADDR_W = 5,
  parameter int AF_MARGIN  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  fifo_ctrl_if.slave bus
);
  localparam int CW = ADDR_W + 1;
  localparam logic [ADDR_W:0] AF_LEVEL = CW'(DEPTH - AF_MARGIN);

  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] rd_ptr;
  logic [ADDR_W:0] count;
  logic            rd_valid;
  logic            full;
  logic            empty;
  logic            almost_full;
  logic            push_ok;
  logic            pop_ok;

  // Flags decode registered state only, so no request-to-flag path exists.
  assign empty       = (wr_ptr == rd_ptr);
  assign full        = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                       (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign almost_full = (count >= AF_LEVEL);

  // rst_n gating keeps the RAM strobes quiet for the whole reset window.
  assign push_ok = bus.wr_en & ~full & rst_n;
  assign pop_ok  = bus.rd_en & ~empty & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr + {{ADDR_W{1'b0}}, push_ok};
      rd_ptr   <= rd_ptr + {{ADDR_W{1'b0}}, pop_ok};
      rd_valid <= pop_ok;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + {{ADDR_W{1'b0}}, 1'b1};
        2'b01:   count <= count - {{ADDR_W{1'b0}}, 1'b1};
        default: count <= count;
      endcase
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow;
  logic underflow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (bus.wr_en && full)
        overflow <= 1'b1;
      if (bus.rd_en && empty)
        underflow <= 1'b1;
    end
  end

  assign bus.overflow  = overflow;
  assign bus.underflow = underflow;
`endif

  assign bus.ram_we      = push_ok;
  assign bus.ram_re      = pop_ok;
  assign bus.ram_waddr   = RAM_ADDR_W'(wr_ptr[ADDR_W-1:0]);
  assign bus.ram_raddr   = RAM_ADDR_W'(rd_ptr[ADDR_W-1:0]);
  assign bus.rd_valid    = rd_valid;
  assign bus.full        = full;
  assign bus.empty       = empty;
  assign bus.almost_full = almost_full;
  assign bus.count       = count;
endmodule
